seg7_scan_display: RTL and testbench

Multiplexed multi-digit 7-segment display driver, the parametrised successor to the single-digit toggle display. It scans `DIGITS` common-anode digits from one clock-enable prescaler, with no derived clocks. A debounced `DISP_SWITCH` press cycles the display source through three modes: PC, packet data low, packet data high. Each displayed value is snapshotted once per scan frame, so every frame shows one coherent number.

---
 rtl/seg7_scan_display.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_display.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan_display                                                |
// | Desc    : Multiplexed DIGITS-wide 7-segment driver with debounced source   |
// |           select; optional leading-zero blanking via SEG7_LZ_BLANK_EN.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_display #(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DISP_SWITCH,
    input  logic [4:0]        PC,
    input  logic [37:0]       PACKET_IN,
    output logic [7:0]        nHEX,
    output logic [DIGITS-1:0] nDIGIT,
    output logic [1:0]        MODE
);

    localparam int c_VW   = 4 * DIGITS;
    localparam int c_DI_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_SC_W = $clog2(SCAN_DIV);
    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]        r_sync;
    logic              r_st;
    logic              r_st_d;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [c_SC_W-1:0] r_sc;
    logic [c_DI_W-1:0] r_di;
    logic [c_VW-1:0]   r_v;
    logic [1:0]        r_mode;
    logic [7:0]        r_nhex;
    logic [DIGITS-1:0] r_ndigit;

    logic [31:0]       w_src;
    logic              w_tick;
    logic              w_wrap;
    logic              w_press;
    logic [c_VW-1:0]   w_vsh;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic              w_dp_on;
    logic [7:0]        w_hex;
    logic              w_unused;

    assign w_unused = ^PACKET_IN[37:32];

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    f_seg = 7'h40;
            4'h1:    f_seg = 7'h79;
            4'h2:    f_seg = 7'h24;
            4'h3:    f_seg = 7'h30;
            4'h4:    f_seg = 7'h19;
            4'h5:    f_seg = 7'h12;
            4'h6:    f_seg = 7'h02;
            4'h7:    f_seg = 7'h58;
            4'h8:    f_seg = 7'h00;
            4'h9:    f_seg = 7'h10;
            4'hA:    f_seg = 7'h08;
            4'hB:    f_seg = 7'h03;
            4'hC:    f_seg = 7'h27;
            4'hD:    f_seg = 7'h21;
            4'hE:    f_seg = 7'h06;
            default: f_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        case (r_mode)
            2'd1:    w_src = {16'b0, PACKET_IN[15:0]};
            2'd2:    w_src = {16'b0, PACKET_IN[31:16]};
            default: w_src = {27'b0, PC};
        endcase
    end

    assign w_tick  = (r_sc == c_SC_W'(SCAN_DIV - 1));
    assign w_wrap  = w_tick && (r_di == c_DI_W'(DIGITS - 1));
    assign w_press = r_st & ~r_st_d;

    assign w_vsh   = r_v >> {r_di, 2'b00};
    assign w_nib   = w_vsh[3:0];
    // A MODE beyond the last digit can never equal di, so no dp is lit.
    assign w_dp_on = (32'(r_di) == 32'(r_mode));

`ifdef SEG7_LZ_BLANK_EN
    logic [c_DI_W-1:0] w_msn;

    always_comb begin
        w_msn = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_v[4*i +: 4] != 4'h0) begin
                w_msn = c_DI_W'(i);
            end
        end
    end

    assign w_blank = (r_di > w_msn);
`else
    assign w_blank = 1'b0;
`endif

    assign w_hex = {~w_dp_on, w_blank ? 7'h7F : f_seg(w_nib)};

    // Switch path: 2-FF synchronizer, run-length debounce, rising-edge press.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync   <= 2'b00;
            r_st     <= 1'b0;
            r_st_d   <= 1'b0;
            r_db_cnt <= '0;
            r_mode   <= 2'd0;
        end else begin
            r_sync <= {r_sync[0], DISP_SWITCH};
            r_st_d <= r_st;
            if (r_sync[1] == r_st) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_st     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (w_press) begin
                r_mode <= (r_mode == 2'd2) ? 2'd0 : r_mode + 2'd1;
            end
        end
    end

    // Scan path: the snapshot uses the pre-press mode on a coincident wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sc     <= '0;
            r_di     <= '0;
            r_v      <= '0;
            r_nhex   <= 8'hFF;
            r_ndigit <= '1;
        end else begin
            if (w_tick) begin
                r_sc <= '0;
                r_di <= w_wrap ? '0 : r_di + 1'b1;
            end else begin
                r_sc <= r_sc + 1'b1;
            end
            if (w_wrap) begin
                r_v <= w_src[c_VW-1:0];
            end
            r_ndigit <= ~(DIGITS'(1) << r_di);
            r_nhex   <= w_hex;
        end
    end

    assign nHEX   = r_nhex;
    assign nDIGIT = r_ndigit;
    assign MODE   = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seg7_scan_display                                             |
// | Desc    : Self-checking bench for seg7_scan_display (DIGITS=4, SCAN_DIV=4, |
// |           DEBOUNCE_CYCLES=3) with a frame-level reference model.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_display;

    localparam int DG = 4;
    localparam int SD = 4;
    localparam int DB = 3;
`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw  = 1'b0;
    logic [4:0]  pc  = '0;
    logic [37:0] pkt = '0;
    logic [7:0]  nhex;
    logic [3:0]  ndig;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .DIGITS          (DG),
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .DISP_SWITCH (sw),
        .PC          (pc),
        .PACKET_IN   (pkt),
        .nHEX        (nhex),
        .nDIGIT      (ndig),
        .MODE        (mode)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position is derived from the cycle count since
    // reset; the switch is judged from its raw history.
    int          m_n, m_mode, m_run, m_di;
    bit          m_st, m_pend, m_s;
    logic [15:0] m_v;
    bit          m_q[$];
    logic [7:0]  e_hex;
    logic [3:0]  e_dig;
    logic [1:0]  e_mode;

    function automatic logic [7:0] seg_code(input int nib);
        case (nib)
            0: return 8'hC0;   1: return 8'hF9;   2: return 8'hA4;   3: return 8'hB0;
            4: return 8'h99;   5: return 8'h92;   6: return 8'h82;   7: return 8'hD8;
            8: return 8'h80;   9: return 8'h90;  10: return 8'h88;  11: return 8'h83;
           12: return 8'hA7;  13: return 8'hA1;  14: return 8'h86;  15: return 8'h8E;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] model_hex(input logic [15:0] v, input int di, input int md);
        logic [7:0] c;
        int rest;
        rest = int'(v >> (4 * di));
        c = seg_code(rest % 16);
        if (LZ && di > 0 && rest == 0) c = 8'hFF;
        if (di == md) c[7] = 1'b0;
        return c;
    endfunction

    function automatic logic [15:0] model_src(input int md, input logic [4:0] p, input logic [37:0] k);
        if (md == 1) return k[15:0];
        if (md == 2) return k[31:16];
        return {11'b0, p};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_n = 0; m_mode = 0; m_run = 0; m_st = 0; m_pend = 0; m_v = '0;
            m_q.delete();
            e_hex = 8'hFF; e_dig = 4'hF; e_mode = 2'd0;
        end else begin
            m_di  = (m_n / SD) % DG;
            e_dig = ~(4'b0001 << m_di);
            e_hex = model_hex(m_v, m_di, m_mode);
            if (m_n % (SD * DG) == SD * DG - 1) m_v = model_src(m_mode, pc, pkt);
            if (m_pend) begin
                m_mode = (m_mode + 1) % 3;
                m_pend = 0;
            end
            m_s = (m_q.size() >= 2) ? m_q[m_q.size() - 2] : 1'b0;
            m_q.push_back(sw);
            if (m_q.size() > 2) void'(m_q.pop_front());
            if (m_s == m_st) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DB) begin
                    m_st   = m_s;
                    m_run  = 0;
                    m_pend = m_s;
                end
            end
            e_mode = 2'(m_mode);
            m_n++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check("model_nHEX", nhex, e_hex);
            check("model_nDIGIT", ndig, e_dig);
            check("model_MODE", mode, e_mode);
        end
    endtask

    task automatic wait_frame();
        logic [3:0] prev;
        bit ok;
        ok   = 1'b0;
        prev = ndig;
        for (int i = 0; i < 3 * SD * DG && !ok; i++) begin
            step(1);
            if (prev != 4'hE && ndig == 4'hE) ok = 1'b1;
            prev = ndig;
        end
        check("frame_start", ok, 1);
    endtask

    task automatic press();
        sw = 1'b1; step(10);
        sw = 1'b0; step(10);
    endtask

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] d;    // {digit3, digit2, digit1, digit0}
        logic [31:0] dlz;  // same with leading-zero blanking
    } vec_t;

    vec_t       tbl [5];
    logic [3:0] walk [4];

    initial begin
        tbl[0] = '{5'h1A, 32'hC0C0_F908, 32'hFFFF_F908};
        tbl[1] = '{5'h00, 32'hC0C0_C040, 32'hFFFF_FF40};
        tbl[2] = '{5'h1F, 32'hC0C0_F90E, 32'hFFFF_F90E};
        tbl[3] = '{5'h07, 32'hC0C0_C058, 32'hFFFF_FF58};
        tbl[4] = '{5'h10, 32'hC0C0_F940, 32'hFFFF_F940};
        walk[0] = 4'hD; walk[1] = 4'hB; walk[2] = 4'h7; walk[3] = 4'hE;

        // Reset and digit walk
        step(3);
        check("rst_nHEX", nhex, 8'hFF);
        check("rst_nDIGIT", ndig, 4'hF);
        check("rst_MODE", mode, 2'd0);
        rst = 1'b0;
        step(1);
        check("first_nDIGIT", ndig, 4'hE);
        check("first_nHEX", nhex, 8'h40);
        for (int i = 0; i < 4; i++) begin
            step(SD);
            check("walk_nDIGIT", ndig, walk[i]);
        end

        // Mode-0 display table
        for (int t = 0; t < 5; t++) begin
            pc = tbl[t].pc;
            wait_frame();
            for (int d = 0; d < DG; d++) begin
                if (d > 0) step(SD);
                check("mode0_digit", nhex, LZ ? tbl[t].dlz[8*d +: 8] : tbl[t].d[8*d +: 8]);
            end
        end

        // Bounce rejection, press latency, mode cycling
        for (int i = 0; i < 40; i++) begin
            sw = ((i / 2) % 2 == 0);
            step(1);
        end
        check("bounce_MODE", mode, 2'd0);
        sw = 1'b1;
        step(5);
        check("press_early_MODE", mode, 2'd0);
        step(1);
        check("press_MODE1", mode, 2'd1);
        step(4);
        sw = 1'b0;
        step(10);
        check("release_MODE", mode, 2'd1);
        press();
        check("press_MODE2", mode, 2'd2);
        press();
        check("press_MODE0", mode, 2'd0);

        // Snapshot coherence across a mid-frame source change
        press();
        check("snap_MODE1", mode, 2'd1);
        pkt = 38'h00BEEF;
        wait_frame();
        wait_frame();
        check("snap_d0", nhex, 8'h8E);
        step(SD); check("snap_d1", nhex, 8'h06);
        pkt = 38'h001234;
        step(SD); check("snap_d2_old", nhex, 8'h86);
        step(SD); check("snap_d3_old", nhex, 8'h83);
        step(SD); check("snap_n0", nhex, 8'h99);
        step(SD); check("snap_n1", nhex, 8'h30);
        step(SD); check("snap_n2", nhex, 8'hA4);
        step(SD); check("snap_n3", nhex, 8'hF9);

        // Press accepted on the frame-wrap cycle
        pc  = 5'h05;
        pkt = 38'h0000FF;
        press();
        press();
        check("sim_MODE0", mode, 2'd0);
        wait_frame();
        step(9);
        sw = 1'b1;
        step(5);
        check("sim_pre_MODE", mode, 2'd0);
        step(1);
        check("sim_wrap_MODE", mode, 2'd1);
        check("sim_wrap_nDIGIT", ndig, 4'h7);
        step(1);
        check("sim_f0_nDIGIT", ndig, 4'hE);
        check("sim_f0_d0", nhex, 8'h92);
        step(SD); check("sim_f0_d1", nhex, LZ ? 8'h7F : 8'h40);
        step(SD); check("sim_f0_d2", nhex, LZ ? 8'hFF : 8'hC0);
        step(SD); check("sim_f0_d3", nhex, LZ ? 8'hFF : 8'hC0);
        sw = 1'b0;
        step(SD); check("sim_f1_d0", nhex, 8'h8E);
        step(SD); check("sim_f1_d1", nhex, 8'h0E);
        step(SD); check("sim_f1_d2", nhex, LZ ? 8'hFF : 8'hC0);
        step(SD); check("sim_f1_d3", nhex, LZ ? 8'hFF : 8'hC0);

        // Reset during a scan and a half-debounced press
        step(10);
        press();
        check("mid_MODE2", mode, 2'd2);
        wait_frame();
        step(4);
        sw = 1'b1;
        step(4);
        rst = 1'b1;
        sw  = 1'b0;
        step(1);
        check("mid_rst_MODE", mode, 2'd0);
        check("mid_rst_nHEX", nhex, 8'hFF);
        check("mid_rst_nDIGIT", ndig, 4'hF);
        rst = 1'b0;
        step(1);
        check("mid_post_nDIGIT", ndig, 4'hE);
        check("mid_post_nHEX", nhex, 8'h40);
        step(20);
        check("mid_post_MODE", mode, 2'd0);

        // Randomized traffic against the model
        for (int sg = 0; sg < 400; sg++) begin
            int len;
            sw  = 1'($urandom);
            len = int'($urandom_range(8, 1));
            for (int c = 0; c < len; c++) begin
                pc  = 5'($urandom);
                pkt = {6'($urandom), $urandom};
                rst = ($urandom_range(299, 0) == 0);
                step(1);
            end
        end
        rst = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
